// File: rtl/atp_bill_pay_ctrl.sv
// Bill-payment kiosk controller: card session, PIN check, note acceptance,
// change computation, timeout/cancel handling and timed result display.
module atp_bill_pay_ctrl #(
    parameter int unsigned              CARD_W       = 8,
    parameter int unsigned              PIN_W        = 4,
    parameter int unsigned              AMT_W        = 16,
    parameter int unsigned              N_DENOM      = 4,
    parameter logic [N_DENOM*AMT_W-1:0] DENOM_VALUES = {16'd1000, 16'd500, 16'd100, 16'd50},
    parameter logic [PIN_W-1:0]         PIN_REF      = 4'b1010,
    parameter int unsigned              MAX_TRIES    = 3,
    parameter int unsigned              TIMEOUT_CYC  = 50,
    parameter int unsigned              HOLD_CYC     = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               card_inserted,
    input  logic [CARD_W-1:0]  card_data,
    input  logic [AMT_W-1:0]   bill_amount,
    input  logic               pin_valid,
    input  logic [PIN_W-1:0]   pin,
    input  logic [N_DENOM-1:0] note_in,
    input  logic               cancel,
    output logic [7:0]         display,
    output logic [AMT_W-1:0]   paid_total,
    output logic [AMT_W-1:0]   change_due,
    output logic               payment_success,
    output logic               payment_fail,
    output logic               payment_timeout
);

    localparam int unsigned SUM_W  = AMT_W + 3;
    localparam int unsigned TRY_W  = $clog2(MAX_TRIES + 1);
    localparam int unsigned TMR_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned HOLD_W = $clog2(HOLD_CYC + 1);
    localparam logic [AMT_W-1:0] AMT_MAX = '1;

    typedef enum logic [7:0] {
        S_IDLE = 8'h00,
        S_CARD = 8'h01,
        S_PIN  = 8'h02,
        S_PAY  = 8'h03,
        S_OK   = 8'h04,
        S_FAIL = 8'h05,
        S_TMO  = 8'h06
    } state_t;

    state_t              state;
    logic                card_prev;
    logic [N_DENOM-1:0]  note_prev;
    logic [CARD_W-1:0]   card_lat;
    logic [AMT_W-1:0]    bill_lat;
    logic [TRY_W-1:0]    tries;
    logic [TMR_W-1:0]    timer;
    logic [HOLD_W-1:0]   hold;

    logic                card_rise;
    logic [N_DENOM-1:0]  note_rise;
    logic [SUM_W-1:0]    note_add;
    logic [SUM_W-1:0]    pay_sum;
    logic [AMT_W-1:0]    pay_sat;
    logic                activity;
    logic [TMR_W-1:0]    timer_n;
    logic                timeout;
    logic [TRY_W-1:0]    tries_n;

    // Edge detection, note value summation, saturation and timer/try increments
    always_comb begin
        card_rise = card_inserted & ~card_prev;
        note_rise = note_in & ~note_prev;
        note_add  = '0;
        for (int i = 0; i < int'(N_DENOM); i++) begin
            if (note_rise[i]) begin
                note_add = note_add + SUM_W'(DENOM_VALUES[i*AMT_W +: AMT_W]);
            end
        end
        pay_sum  = SUM_W'(paid_total) + note_add;
        pay_sat  = (pay_sum > SUM_W'(AMT_MAX)) ? AMT_MAX : pay_sum[AMT_W-1:0];
        activity = ((state == S_PIN) && pin_valid) || ((state == S_PAY) && (|note_rise));
        timer_n  = activity ? '0 : timer + TMR_W'(1);
        timeout  = (timer_n >= TMR_W'(TIMEOUT_CYC));
        tries_n  = tries + TRY_W'(1);
    end

    // Session FSM with registered display, totals and result flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= S_IDLE;
            display         <= 8'h00;
            paid_total      <= '0;
            change_due      <= '0;
            payment_success <= 1'b0;
            payment_fail    <= 1'b0;
            payment_timeout <= 1'b0;
            card_prev       <= 1'b0;
            note_prev       <= '0;
            card_lat        <= '0;
            bill_lat        <= '0;
            tries           <= '0;
            timer           <= '0;
            hold            <= '0;
        end else begin
            card_prev <= card_inserted;
            note_prev <= note_in;
            case (state)
                S_IDLE: begin
                    if (card_rise) begin
                        state      <= S_CARD;
                        display    <= S_CARD;
                        card_lat   <= card_data;
                        bill_lat   <= bill_amount;
                        paid_total <= '0;
                        change_due <= '0;
                        tries      <= '0;
                        timer      <= '0;
                    end
                end
                S_CARD: begin
                    if (card_lat == '0) begin
                        state        <= S_FAIL;
                        display      <= S_FAIL;
                        payment_fail <= 1'b1;
                        hold         <= '0;
                    end else begin
                        state   <= S_PIN;
                        display <= S_PIN;
                    end
                end
                S_PIN: begin
                    timer <= timer_n;
                    if (cancel) begin
                        state        <= S_FAIL;
                        display      <= S_FAIL;
                        payment_fail <= 1'b1;
                        change_due   <= paid_total;
                        hold         <= '0;
                    end else if (timeout) begin
                        state           <= S_TMO;
                        display         <= S_TMO;
                        payment_timeout <= 1'b1;
                        change_due      <= paid_total;
                        hold            <= '0;
                    end else if (pin_valid) begin
                        if (pin == PIN_REF) begin
                            state   <= S_PAY;
                            display <= S_PAY;
                        end else begin
                            tries <= tries_n;
                            if (tries_n >= TRY_W'(MAX_TRIES)) begin
                                state        <= S_FAIL;
                                display      <= S_FAIL;
                                payment_fail <= 1'b1;
                                hold         <= '0;
                            end
                        end
                    end
                end
                S_PAY: begin
                    timer      <= timer_n;
                    paid_total <= pay_sat;
                    if (cancel) begin
                        state        <= S_FAIL;
                        display      <= S_FAIL;
                        payment_fail <= 1'b1;
                        change_due   <= pay_sat;
                        hold         <= '0;
                    end else if (timeout) begin
                        state           <= S_TMO;
                        display         <= S_TMO;
                        payment_timeout <= 1'b1;
                        change_due      <= pay_sat;
                        hold            <= '0;
                    end else if (pay_sat >= bill_lat) begin
                        state           <= S_OK;
                        display         <= S_OK;
                        payment_success <= 1'b1;
                        change_due      <= pay_sat - bill_lat;
                        hold            <= '0;
                    end
                end
                S_OK, S_FAIL, S_TMO: begin
                    if (hold == HOLD_W'(HOLD_CYC - 1)) begin
                        state           <= S_IDLE;
                        display         <= S_IDLE;
                        payment_success <= 1'b0;
                        payment_fail    <= 1'b0;
                        payment_timeout <= 1'b0;
                    end else begin
                        hold <= hold + HOLD_W'(1);
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    display <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_atp_bill_pay_ctrl.sv
// Directed bench for atp_bill_pay_ctrl: per-cycle vector table plus
// hand-written timeout and asynchronous-reset sequences.
module tb_atp_bill_pay_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        card_inserted;
    logic [7:0]  card_data;
    logic [15:0] bill_amount;
    logic        pin_valid;
    logic [3:0]  pin;
    logic [3:0]  note_in;
    logic        cancel;
    logic [7:0]  display;
    logic [15:0] paid_total;
    logic [15:0] change_due;
    logic        payment_success;
    logic        payment_fail;
    logic        payment_timeout;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        card;
        logic [7:0]  data;
        logic [15:0] bill;
        logic        pv;
        logic [3:0]  pin;
        logic [3:0]  notes;
        logic        cancel;
        logic [7:0]  disp;
        logic [15:0] paid;
        logic [15:0] chg;
        logic [2:0]  flags; // {success, fail, timeout}
    } vec_t;

    vec_t tbl[$];

    atp_bill_pay_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .card_inserted   (card_inserted),
        .card_data       (card_data),
        .bill_amount     (bill_amount),
        .pin_valid       (pin_valid),
        .pin             (pin),
        .note_in         (note_in),
        .cancel          (cancel),
        .display         (display),
        .paid_total      (paid_total),
        .change_due      (change_due),
        .payment_success (payment_success),
        .payment_fail    (payment_fail),
        .payment_timeout (payment_timeout)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic c, input logic [7:0] d, input logic [15:0] b,
                                input logic pv, input logic [3:0] p, input logic [3:0] n,
                                input logic cx, input logic [7:0] ed, input logic [15:0] ep,
                                input logic [15:0] ec, input logic [2:0] ef);
        vec_t v;
        v.card = c; v.data = d; v.bill = b; v.pv = pv; v.pin = p; v.notes = n;
        v.cancel = cx; v.disp = ed; v.paid = ep; v.chg = ec; v.flags = ef;
        return v;
    endfunction

    task automatic check_out(input string tag, input int idx, input logic [7:0] ed,
                             input logic [15:0] ep, input logic [15:0] ec, input logic [2:0] ef);
        logic [2:0] fl;
        fl = {payment_success, payment_fail, payment_timeout};
        total++;
        if (display !== ed) begin
            bad++;
            $display("FAIL %s[%0d] display: got %0h want %0h", tag, idx, display, ed);
        end
        total++;
        if (paid_total !== ep) begin
            bad++;
            $display("FAIL %s[%0d] paid_total: got %0d want %0d", tag, idx, paid_total, ep);
        end
        total++;
        if (change_due !== ec) begin
            bad++;
            $display("FAIL %s[%0d] change_due: got %0d want %0d", tag, idx, change_due, ec);
        end
        total++;
        if (fl !== ef) begin
            bad++;
            $display("FAIL %s[%0d] flags: got %b want %b", tag, idx, fl, ef);
        end
    endtask

    // Drive one cycle of inputs on the falling edge, check just after the rising edge
    task automatic apply(input vec_t v, input string tag, input int idx);
        @(negedge clk);
        card_inserted = v.card;
        card_data     = v.data;
        bill_amount   = v.bill;
        pin_valid     = v.pv;
        pin           = v.pin;
        note_in       = v.notes;
        cancel        = v.cancel;
        @(posedge clk);
        #1;
        check_out(tag, idx, v.disp, v.paid, v.chg, v.flags);
    endtask

    // Session start, CARD, correct PIN: lands in PAY
    task automatic open_pay(input logic [7:0] d, input logic [15:0] b, input string tag);
        apply(mk(1, d, b, 0, 4'h0, 4'h0, 0, 8'h01, 0, 0, 3'b000), tag, 0);
        apply(mk(1, d, b, 0, 4'h0, 4'h0, 0, 8'h02, 0, 0, 3'b000), tag, 1);
        apply(mk(1, d, b, 1, 4'b1010, 4'h0, 0, 8'h03, 0, 0, 3'b000), tag, 2);
    endtask

    // Result display: three more held cycles then IDLE with totals retained
    task automatic hold_rows(input logic [7:0] ed, input logic [15:0] ep,
                             input logic [15:0] ec, input logic [2:0] ef);
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, ed, ep, ec, ef));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, ed, ep, ec, ef));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, ed, ep, ec, ef));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 8'h00, ep, ec, 3'b000));
    endtask

    initial begin
        reset = 1'b1; card_inserted = 0; card_data = 0; bill_amount = 0;
        pin_valid = 0; pin = 0; note_in = 0; cancel = 0;

        // A: bill 1550, notes 1000/500/100 on separate cycles
        tbl.push_back(mk(1, 8'hAB, 1550, 0, 4'h0,    4'h0, 0, 8'h01, 0, 0, 3'b000));
        tbl.push_back(mk(1, 8'hAB, 1550, 0, 4'h0,    4'h0, 0, 8'h02, 0, 0, 3'b000));
        tbl.push_back(mk(1, 8'hAB, 1550, 1, 4'b1010, 4'h0, 0, 8'h03, 0, 0, 3'b000));
        tbl.push_back(mk(1, 8'hAB, 1550, 0, 4'h0, 4'b1000, 0, 8'h03, 1000, 0, 3'b000));
        tbl.push_back(mk(1, 8'hAB, 1550, 0, 4'h0, 4'b0100, 0, 8'h03, 1500, 0, 3'b000));
        tbl.push_back(mk(1, 8'hAB, 1550, 0, 4'h0, 4'b0010, 0, 8'h04, 1600, 50, 3'b100));
        hold_rows(8'h04, 1600, 50, 3'b100);
        // B1: three wrong PINs -> FAIL, totals cleared by session start
        tbl.push_back(mk(1, 8'hCD, 100, 0, 4'h0,    4'h0, 0, 8'h01, 0, 0, 3'b000));
        tbl.push_back(mk(1, 8'hCD, 100, 0, 4'h0,    4'h0, 0, 8'h02, 0, 0, 3'b000));
        tbl.push_back(mk(1, 8'hCD, 100, 1, 4'b0101, 4'h0, 0, 8'h02, 0, 0, 3'b000));
        tbl.push_back(mk(1, 8'hCD, 100, 0, 4'h0,    4'h0, 0, 8'h02, 0, 0, 3'b000));
        tbl.push_back(mk(1, 8'hCD, 100, 1, 4'b0101, 4'h0, 0, 8'h02, 0, 0, 3'b000));
        tbl.push_back(mk(1, 8'hCD, 100, 1, 4'b0101, 4'h0, 0, 8'h05, 0, 0, 3'b010));
        hold_rows(8'h05, 0, 0, 3'b010);
        // B2: two wrong then correct -> PAY, then cancel with nothing paid
        tbl.push_back(mk(1, 8'hCD, 100, 0, 4'h0,    4'h0, 0, 8'h01, 0, 0, 3'b000));
        tbl.push_back(mk(1, 8'hCD, 100, 0, 4'h0,    4'h0, 0, 8'h02, 0, 0, 3'b000));
        tbl.push_back(mk(1, 8'hCD, 100, 1, 4'b0101, 4'h0, 0, 8'h02, 0, 0, 3'b000));
        tbl.push_back(mk(1, 8'hCD, 100, 1, 4'b0101, 4'h0, 0, 8'h02, 0, 0, 3'b000));
        tbl.push_back(mk(1, 8'hCD, 100, 1, 4'b1010, 4'h0, 0, 8'h03, 0, 0, 3'b000));
        tbl.push_back(mk(1, 8'hCD, 100, 0, 4'h0,    4'h0, 1, 8'h05, 0, 0, 3'b010));
        hold_rows(8'h05, 0, 0, 3'b010);
        // D1: bill 1500, 1000 and 500 in the same cycle
        tbl.push_back(mk(1, 8'h11, 1500, 0, 4'h0,    4'h0, 0, 8'h01, 0, 0, 3'b000));
        tbl.push_back(mk(1, 8'h11, 1500, 0, 4'h0,    4'h0, 0, 8'h02, 0, 0, 3'b000));
        tbl.push_back(mk(1, 8'h11, 1500, 1, 4'b1010, 4'h0, 0, 8'h03, 0, 0, 3'b000));
        tbl.push_back(mk(1, 8'h11, 1500, 0, 4'h0, 4'b1100, 0, 8'h04, 1500, 0, 3'b100));
        hold_rows(8'h04, 1500, 0, 3'b100);
        // D2: card_data 0 -> FAIL straight from CARD
        tbl.push_back(mk(1, 8'h00, 1500, 0, 4'h0, 4'h0, 0, 8'h01, 0, 0, 3'b000));
        tbl.push_back(mk(1, 8'h00, 1500, 0, 4'h0, 4'h0, 0, 8'h05, 0, 0, 3'b010));
        hold_rows(8'h05, 0, 0, 3'b010);
        // E1: cancel after a 100 note refunds 100
        tbl.push_back(mk(1, 8'h22, 1550, 0, 4'h0,    4'h0, 0, 8'h01, 0, 0, 3'b000));
        tbl.push_back(mk(1, 8'h22, 1550, 0, 4'h0,    4'h0, 0, 8'h02, 0, 0, 3'b000));
        tbl.push_back(mk(1, 8'h22, 1550, 1, 4'b1010, 4'h0, 0, 8'h03, 0, 0, 3'b000));
        tbl.push_back(mk(1, 8'h22, 1550, 0, 4'h0, 4'b0010, 0, 8'h03, 100, 0, 3'b000));
        tbl.push_back(mk(1, 8'h22, 1550, 0, 4'h0, 4'b0000, 1, 8'h05, 100, 100, 3'b010));
        hold_rows(8'h05, 100, 100, 3'b010);
        // E2: a 50 note arriving on the cancel cycle is included in the refund
        tbl.push_back(mk(1, 8'h22, 1550, 0, 4'h0,    4'h0, 0, 8'h01, 0, 0, 3'b000));
        tbl.push_back(mk(1, 8'h22, 1550, 0, 4'h0,    4'h0, 0, 8'h02, 0, 0, 3'b000));
        tbl.push_back(mk(1, 8'h22, 1550, 1, 4'b1010, 4'h0, 0, 8'h03, 0, 0, 3'b000));
        tbl.push_back(mk(1, 8'h22, 1550, 0, 4'h0, 4'b0010, 0, 8'h03, 100, 0, 3'b000));
        tbl.push_back(mk(1, 8'h22, 1550, 0, 4'h0, 4'b0001, 1, 8'h05, 150, 150, 3'b010));
        hold_rows(8'h05, 150, 150, 3'b010);
        // G: zero bill completes on the first PAY cycle
        tbl.push_back(mk(1, 8'h5A, 0, 0, 4'h0,    4'h0, 0, 8'h01, 0, 0, 3'b000));
        tbl.push_back(mk(1, 8'h5A, 0, 0, 4'h0,    4'h0, 0, 8'h02, 0, 0, 3'b000));
        tbl.push_back(mk(1, 8'h5A, 0, 1, 4'b1010, 4'h0, 0, 8'h03, 0, 0, 3'b000));
        tbl.push_back(mk(1, 8'h5A, 0, 0, 4'h0,    4'h0, 0, 8'h04, 0, 0, 3'b100));
        hold_rows(8'h04, 0, 0, 3'b100);

        // Reset state
        #12;
        check_out("reset", 0, 8'h00, 0, 0, 3'b000);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], "tbl", i);
        end

        // C1: no activity in PAY -> timeout on the 50th idle cycle
        open_pay(8'h33, 1550, "tmo1");
        for (int k = 1; k <= 50; k++) begin
            if (k < 50) apply(mk(1, 8'h33, 1550, 0, 0, 0, 0, 8'h03, 0, 0, 3'b000), "tmo1", k);
            else        apply(mk(1, 8'h33, 1550, 0, 0, 0, 0, 8'h06, 0, 0, 3'b001), "tmo1", k);
        end
        for (int k = 0; k < 3; k++)
            apply(mk(0, 0, 0, 0, 0, 0, 0, 8'h06, 0, 0, 3'b001), "tmo1h", k);
        apply(mk(0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 3'b000), "tmo1i", 0);

        // C2: one 500 note, then silence -> timeout refunds 500
        open_pay(8'h34, 1550, "tmo2");
        apply(mk(1, 8'h34, 1550, 0, 0, 4'b0100, 0, 8'h03, 500, 0, 3'b000), "tmo2", 3);
        for (int k = 1; k <= 50; k++) begin
            if (k < 50) apply(mk(1, 8'h34, 1550, 0, 0, 0, 0, 8'h03, 500, 0, 3'b000), "tmo2", k);
            else        apply(mk(1, 8'h34, 1550, 0, 0, 0, 0, 8'h06, 500, 500, 3'b001), "tmo2", k);
        end
        for (int k = 0; k < 3; k++)
            apply(mk(0, 0, 0, 0, 0, 0, 0, 8'h06, 500, 500, 3'b001), "tmo2h", k);
        apply(mk(0, 0, 0, 0, 0, 0, 0, 8'h00, 500, 500, 3'b000), "tmo2i", 0);

        // F: asynchronous reset mid-PAY, then a normal session
        open_pay(8'h44, 1550, "rst");
        apply(mk(1, 8'h44, 1550, 0, 0, 4'b1000, 0, 8'h03, 1000, 0, 3'b000), "rst", 3);
        @(negedge clk);
        #2;
        reset = 1'b1;
        card_inserted = 1'b0;
        note_in = 4'h0;
        #1;
        check_out("rst_async", 0, 8'h00, 0, 0, 3'b000);
        @(negedge clk);
        reset = 1'b0;
        open_pay(8'h45, 1550, "post");
        apply(mk(1, 8'h45, 1550, 0, 0, 4'b1000, 0, 8'h03, 1000, 0, 3'b000), "post", 3);
        apply(mk(1, 8'h45, 1550, 0, 0, 4'b0100, 0, 8'h03, 1500, 0, 3'b000), "post", 4);
        apply(mk(1, 8'h45, 1550, 0, 0, 4'b0001, 0, 8'h04, 1550, 0, 3'b100), "post", 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/atp_bill_pay_ctrl.md
ATP_BILL_PAY_CTRL -- requirements
Module: atp_bill_pay_ctrl

Interface
REQ-001 Parameter CARD_W, default 8, card data width.
REQ-002 Parameter PIN_W, default 4, PIN width.
REQ-003 Parameter AMT_W, default 16, amount width (bill, paid, change).
REQ-004 Parameter N_DENOM, default 4, number of note inputs.
REQ-005 Parameter DENOM_VALUES, default {16'd1000,16'd500,16'd100,16'd50}, packed N_DENOM*AMT_W; slice i is the value of note_in[i], so bit 0 is 50.
REQ-006 Parameter PIN_REF, default 4'b1010, accepted PIN.
REQ-007 Parameter MAX_TRIES, default 3, wrong-PIN limit.
REQ-008 Parameter TIMEOUT_CYC, default 50, inactivity limit in cycles.
REQ-009 Parameter HOLD_CYC, default 4, result display duration in cycles.
REQ-010 Port clk  in  1  single clock; all logic on rising edge.
REQ-011 Port reset  in  1  asynchronous, active-high reset.
REQ-012 Port card_inserted  in  1  card presence level; session starts on its rising edge.
REQ-013 Port card_data  in  CARD_W  card ID, sampled on the card_inserted rising edge.
REQ-014 Port bill_amount  in  AMT_W  amount due, sampled on the card_inserted rising edge.
REQ-015 Port pin_valid  in  1  one-cycle strobe qualifying pin.
REQ-016 Port pin  in  PIN_W  entered PIN.
REQ-017 Port note_in  in  N_DENOM  note levels; each rising edge is one note.
REQ-018 Port cancel  in  1  user abort, level-sampled.
REQ-019 Port display  out  8  state code.
REQ-020 Port paid_total  out  AMT_W  amount accepted this session.
REQ-021 Port change_due  out  AMT_W  change or refund.
REQ-022 Ports payment_success, payment_fail, payment_timeout  out  1 each  result flags.

Function
REQ-023 The FSM SHALL have these states and display codes: IDLE 8'h00, CARD 8'h01, PIN 8'h02, PAY 8'h03, OK 8'h04, FAIL 8'h05, TMO 8'h06; display is registered and equals the current state code.
REQ-024 IDLE: on a card_inserted rising edge (registered previous-value compare) the FSM SHALL go to CARD, latch card_data and bill_amount, and clear paid_total, change_due, the try count and the timer.
REQ-025 CARD SHALL last one cycle: latched card_data == 0 goes to FAIL, otherwise to PIN.
REQ-026 PIN: on pin_valid with pin == PIN_REF go to PAY; on a mismatch increment tries, and go to FAIL when tries reaches MAX_TRIES, else stay in PIN.
REQ-027 PAY: each cycle, add the sum of DENOM_VALUES for every note_in bit with a rising edge that cycle; simultaneous notes SHALL all be counted.
REQ-028 paid_total SHALL saturate at 2^AMT_W-1; intermediate sums use AMT_W+3 bits.
REQ-029 When the updated sum is >= the latched bill, on the same edge go to OK with change_due = sum - bill; a latched bill of 0 goes to OK on the first PAY cycle with change_due = 0.
REQ-030 The inactivity timer SHALL run in PIN and PAY, clear on pin_valid or any note edge, and on reaching TIMEOUT_CYC go to TMO with change_due = paid_total.
REQ-031 cancel in PIN or PAY SHALL go to FAIL with change_due = paid_total, including notes counted on the cancel cycle.
REQ-032 Priority SHALL be cancel > timeout > payment completion or PIN result.
REQ-033 In OK, FAIL and TMO, exactly the matching flag SHALL be high for HOLD_CYC cycles, then the FSM returns to IDLE and clears the flag.
REQ-034 paid_total and change_due SHALL hold their values until the next session start.
REQ-035 card_inserted edges, pin_valid and note edges SHALL be ignored outside their owning states; edge-detect registers still track the inputs.
REQ-036 Only one result flag SHALL ever be high at a time.

Reset
REQ-037 Asserting reset, including mid-session, SHALL immediately force IDLE with display, paid_total, change_due and all flags at 0, and clear tries, the timer, edge registers and latched data.
REQ-038 After reset deasserts, the first card_inserted rising edge SHALL start a normal session.

Verification
REQ-039 Bill 1550, card 8'hAB, pin 1010, then notes 1000, 500, 100 on separate cycles -> paid_total 1600, payment_success for 4 cycles, change_due 50, display 04.
REQ-040 Card 8'hCD, three pin_valid with 0101 -> payment_fail, display 05, paid_total 0; two wrong entries then 1010 -> PAY.
REQ-041 Correct PIN and no activity for 50 cycles -> payment_timeout; repeat with one 500 note then silence -> change_due 500.
REQ-042 Bill 1500, notes 1000 and 500 rising in the same cycle -> paid_total 1500, success, change_due 0; card_data 0 -> FAIL directly from CARD.
REQ-043 Cancel after a 100 note -> payment_fail, change_due 100.
REQ-044 Reset asserted mid-PAY -> all outputs 0 asynchronously, display 00; a following session completes normally.
